alu_srcb_imm_stage: RTL and testbench
=====================================

Name: alu_srcb_imm_stage

Overview:
- Parametrised ALU source-B operand stage: decodes every RV immediate format (I/S/B/U/J/shamt) or forwards RS2 data, and extends it to XLEN.
- Sits between decode and execute. Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so execute-side stalls never cut combinationally into decode.
- Adds pipeline flush and an illegal-select flag.

Parameters:
- XLEN, 32, operand width; legal values 32 or 64.
- SIGN_EXT, 1, 1 = RISC-V sign extension of I/S/B/J immediates; 0 = zero extension (legacy compatibility mode).
- SHAMT_W, 5, shift-amount field width; must be 5 when XLEN=32 and 6 when XLEN=64.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; drops all held entries.
- in_valid  in  1  decode presents an entry.
- in_ready  out  1  stage can accept an entry; registered output.
- in_instr  in  32  raw instruction word.
- in_sel  in  3  operand select: 0 ZERO, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 RS2.
- in_rs2  in  XLEN  register-file RD2 value.
- out_valid  out  1  out_operand is valid.
- out_ready  in  1  execute accepts the entry.
- out_operand  out  XLEN  extended operand.
- out_illegal  out  1  reserved; driven 0 (all 3-bit codes are decoded). Kept for future widening of in_sel.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_operand=0, out_illegal=0.
  - Skid entry cleared.
  - in_ready=1 on the first cycle after reset.
  - rst has priority over flush; flush has priority over in_valid.
- Immediate formats (s = instr[31] when SIGN_EXT=1, else 0; each extended to XLEN):
  - I: {s.., instr[31:20]}
  - S: {s.., instr[31:25], instr[11:7]}
  - B: {s.., instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - J: {s.., instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
  - U: {instr[31:12], 12'b0}, always sign-extended from bit 31 when XLEN=64, regardless of SIGN_EXT.
  - SHAMT: zero-extended instr[20+SHAMT_W-1:20].
  - RS2: in_rs2 unchanged.
  - ZERO: all zeros.
- Decode is combinational on the input side. Registered latency is exactly 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_operand and out_valid must hold stable while out_valid && !out_ready.
- Skid buffer (two entries: MAIN drives the outputs, SKID holds overflow):
  - in_ready = !skid_full, registered.
  - If an entry is accepted while MAIN is valid and not draining, it goes to SKID, and in_ready drops on the next cycle.
  - When MAIN drains and SKID is full, SKID moves to MAIN in the same edge and in_ready returns to 1.
  - Accept and drain in the same cycle with SKID empty: the new entry replaces MAIN, out_valid stays 1, no bubble.
  - Order is strictly FIFO; no entry is ever lost or duplicated.
- Flush:
  - Clears MAIN and SKID valid bits; out_valid=0 and in_ready=1 on the next cycle.
  - An input presented in the flush cycle is discarded.
  - out_operand keeps its last value (don't-care while invalid).
- Throughput: 1 entry/cycle while out_ready=1.

Decomposition:
- Shared package (riscv_pkg): operand-select enum (SEL_ZERO..SEL_RS2) and the XLEN default constant.
- One natural sub-module: imm_decode, a pure combinational format decoder parametrised by XLEN and SIGN_EXT.
- Skid buffer logic stays inline in this block.

Test Plan:
- I-type, SIGN_EXT=1, XLEN=32: instr=0xFFF00093 (addi x1,x0,-1), sel=I -> out_operand=0xFFFFFFFF one cycle after acceptance. With SIGN_EXT=0 -> 0x00000FFF.
- Every format, XLEN=32, SIGN_EXT=1:
  - S: instr=0xFE112E23 -> 0xFFFFFFFC.
  - B: instr=0xFE000EE3 -> 0xFFFFFFFC.
  - J: instr=0xFFDFF06F -> 0xFFFFFFFC.
  - U: instr=0x123450B7 -> 0x12345000.
  - SHAMT: instr=0x41F0D093 -> 0x0000001F.
  - RS2: rs2=0xDEADBEEF -> 0xDEADBEEF.
- XLEN=64, U-type: instr=0x800000B7 -> 0xFFFFFFFF80000000. SHAMT_W=6, instr[25:20]=63 -> 0x3F.
- Backpressure: stream 4 entries with out_ready=0 for 3 cycles -> in_ready falls after the 2nd accept. Outputs then drain in order 1,2,3,4 with no loss; in_ready returns 1 the cycle after SKID empties.
- Flush with both entries full -> next cycle out_valid=0, in_ready=1; the next accepted entry appears alone.
- rst asserted mid-stream together with flush and in_valid=1 -> all outputs at reset values next cycle; no entry emerges.

Source files
------------

// File: rtl/alu_srcb_imm_stage_pkg.sv
// Shared types for the ALU source-B operand stage: operand-select codes and width defaults.
package alu_srcb_imm_stage_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned SEL_W        = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_ZERO  = 3'd0,
    SEL_I     = 3'd1,
    SEL_S     = 3'd2,
    SEL_B     = 3'd3,
    SEL_U     = 3'd4,
    SEL_J     = 3'd5,
    SEL_SHAMT = 3'd6,
    SEL_RS2   = 3'd7
  } op_sel_e;

endpackage

// File: rtl/alu_srcb_imm_stage_if.sv
// Decode-side request and execute-side response signals of the source-B stage.
interface alu_srcb_imm_stage_if
  import alu_srcb_imm_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);
  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  in_instr;
  op_sel_e             in_sel;
  logic [XLEN-1:0]     in_rs2;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_operand;
  logic                out_illegal;

  modport master (
    output in_valid, in_instr, in_sel, in_rs2, out_ready,
    input  in_ready, out_valid, out_operand, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_sel, in_rs2, out_ready,
    output in_ready, out_valid, out_operand, out_illegal
  );
endinterface

// File: rtl/alu_srcb_imm_stage_imm_decode.sv
// Combinational RV immediate-format decoder; selects and extends the source-B operand to XLEN.
module alu_srcb_imm_stage_imm_decode
  import alu_srcb_imm_stage_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter bit          SIGN_EXT = 1'b1,
  parameter int unsigned SHAMT_W  = 5
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  op_sel_e            sel_i,
  input  logic [XLEN-1:0]    rs2_i,
  output logic [XLEN-1:0]    operand_c_o
);
  logic            s;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic            unused_opcode;

  assign s = SIGN_EXT ? instr_i[31] : 1'b0;

  assign imm_i  = {{(XLEN-12){s}}, instr_i[31:20]};
  assign imm_s  = {{(XLEN-12){s}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{(XLEN-13){s}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j  = {{(XLEN-21){s}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  // U always follows bit 31 so LUI/AUIPC stay correct on RV64 even in legacy zero-extend mode.
  assign imm_u  = XLEN'($signed({instr_i[31:12], 12'b0}));
  assign imm_sh = XLEN'(instr_i[20 +: SHAMT_W]);

  assign unused_opcode = ^instr_i[6:0];

  always_comb begin
    operand_c_o = '0;
    case (sel_i)
      SEL_ZERO:  operand_c_o = '0;
      SEL_I:     operand_c_o = imm_i;
      SEL_S:     operand_c_o = imm_s;
      SEL_B:     operand_c_o = imm_b;
      SEL_U:     operand_c_o = imm_u;
      SEL_J:     operand_c_o = imm_j;
      SEL_SHAMT: operand_c_o = imm_sh;
      SEL_RS2:   operand_c_o = rs2_i;
    endcase
  end
endmodule

// File: rtl/alu_srcb_imm_stage.sv
// ALU source-B operand stage: decode/extend the operand, then register it behind a
// 2-entry skid buffer so execute-side stalls never reach decode combinationally.
module alu_srcb_imm_stage
  import alu_srcb_imm_stage_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter bit          SIGN_EXT = 1'b1,
  parameter int unsigned SHAMT_W  = 5
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 flush,
  alu_srcb_imm_stage_if.slave bus
);
  logic [XLEN-1:0] dec_c;
  logic            acc_c, drain_c;

  logic            main_vld_q, main_vld_d;
  logic [XLEN-1:0] main_op_q,  main_op_d;
  logic            skid_vld_q, skid_vld_d;
  logic [XLEN-1:0] skid_op_q,  skid_op_d;
  logic            in_ready_q, in_ready_d;
  logic            illegal_q,  illegal_d;

  alu_srcb_imm_stage_imm_decode #(
    .XLEN     (XLEN),
    .SIGN_EXT (SIGN_EXT),
    .SHAMT_W  (SHAMT_W)
  ) u_dec (
    .instr_i     (bus.in_instr),
    .sel_i       (bus.in_sel),
    .rs2_i       (bus.in_rs2),
    .operand_c_o (dec_c)
  );

  assign acc_c   = bus.in_valid && in_ready_q;
  assign drain_c = main_vld_q && bus.out_ready;

  // Next-state: drain first (promoting SKID), then place a new entry in the free slot.
  always_comb begin
    main_vld_d = main_vld_q;
    main_op_d  = main_op_q;
    skid_vld_d = skid_vld_q;
    skid_op_d  = skid_op_q;
    illegal_d  = 1'b0;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (drain_c) begin
        if (skid_vld_q) begin
          main_vld_d = 1'b1;
          main_op_d  = skid_op_q;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = 1'b0;
        end
      end
      // in_ready_q implies SKID was empty, so an accept always has a free slot.
      if (acc_c) begin
        if (!main_vld_d) begin
          main_vld_d = 1'b1;
          main_op_d  = dec_c;
        end else begin
          skid_vld_d = 1'b1;
          skid_op_d  = dec_c;
        end
      end
    end
    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_op_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_op_q  <= '0;
      in_ready_q <= 1'b1;
      illegal_q  <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      main_op_q  <= main_op_d;
      skid_vld_q <= skid_vld_d;
      skid_op_q  <= skid_op_d;
      in_ready_q <= in_ready_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_vld_q;
  assign bus.out_operand = main_op_q;
  assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_alu_srcb_imm_stage.sv
// Directed bench: three stage instances (RV32 sign-ext, RV32 zero-ext, RV64) driven in lockstep.
module tb_alu_srcb_imm_stage;
  import alu_srcb_imm_stage_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   n_cmp;
  int   n_err;

  alu_srcb_imm_stage_if #(.XLEN(32)) b0 ();
  alu_srcb_imm_stage_if #(.XLEN(32)) b1 ();
  alu_srcb_imm_stage_if #(.XLEN(64)) b2 ();

  alu_srcb_imm_stage #(.XLEN(32), .SIGN_EXT(1'b1), .SHAMT_W(5)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b0));
  alu_srcb_imm_stage #(.XLEN(32), .SIGN_EXT(1'b0), .SHAMT_W(5)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b1));
  alu_srcb_imm_stage #(.XLEN(64), .SIGN_EXT(1'b1), .SHAMT_W(6)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] instr, input op_sel_e sel,
                       input logic [63:0] rs2, input logic ordy);
    b0.in_valid = v; b0.in_instr = instr; b0.in_sel = sel; b0.in_rs2 = rs2[31:0]; b0.out_ready = ordy;
    b1.in_valid = v; b1.in_instr = instr; b1.in_sel = sel; b1.in_rs2 = rs2[31:0]; b1.out_ready = ordy;
    b2.in_valid = v; b2.in_instr = instr; b2.in_sel = sel; b2.in_rs2 = rs2;       b2.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, SEL_ZERO, 64'h0, 1'b1);
    step(); step();
    rst = 1'b0;

    chk("rst_out_valid",   64'(b0.out_valid),   64'h0);
    chk("rst_out_operand", 64'(b0.out_operand), 64'h0);
    chk("rst_out_illegal", 64'(b0.out_illegal), 64'h0);
    chk("rst_in_ready",    64'(b0.in_ready),    64'h1);

    // Back-to-back formats with out_ready=1: one entry per cycle, 1-cycle latency.
    drive(1'b1, 32'hFFF00093, SEL_I, 64'h0, 1'b1); step();
    chk("i_valid",   64'(b0.out_valid),   64'h1);
    chk("i_sext32",  64'(b0.out_operand), 64'hFFFF_FFFF);
    chk("i_zext32",  64'(b1.out_operand), 64'h0000_0FFF);
    chk("i_sext64",  64'(b2.out_operand), 64'hFFFF_FFFF_FFFF_FFFF);

    drive(1'b1, 32'hFE112E23, SEL_S, 64'h0, 1'b1); step();
    chk("s_sext32",  64'(b0.out_operand), 64'hFFFF_FFFC);
    chk("s_zext32",  64'(b1.out_operand), 64'h0000_0FFC);

    drive(1'b1, 32'hFE000EE3, SEL_B, 64'h0, 1'b1); step();
    chk("b_sext32",  64'(b0.out_operand), 64'hFFFF_FFFC);
    chk("b_zext32",  64'(b1.out_operand), 64'h0000_1FFC);

    drive(1'b1, 32'hFFDFF06F, SEL_J, 64'h0, 1'b1); step();
    chk("j_sext32",  64'(b0.out_operand), 64'hFFFF_FFFC);
    chk("j_zext32",  64'(b1.out_operand), 64'h001F_FFFC);
    chk("j_sext64",  64'(b2.out_operand), 64'hFFFF_FFFF_FFFF_FFFC);

    drive(1'b1, 32'h123450B7, SEL_U, 64'h0, 1'b1); step();
    chk("u_32",      64'(b0.out_operand), 64'h1234_5000);
    chk("u_64",      64'(b2.out_operand), 64'h0000_0000_1234_5000);

    drive(1'b1, 32'h41F0D093, SEL_SHAMT, 64'h0, 1'b1); step();
    chk("shamt_32",  64'(b0.out_operand), 64'h1F);
    chk("shamt_64",  64'(b2.out_operand), 64'h1F);

    drive(1'b1, 32'h0, SEL_RS2, 64'hCAFEF00D_DEADBEEF, 1'b1); step();
    chk("rs2_32",    64'(b0.out_operand), 64'hDEAD_BEEF);
    chk("rs2_64",    64'(b2.out_operand), 64'hCAFEF00D_DEADBEEF);

    drive(1'b1, 32'hFFFFFFFF, SEL_ZERO, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1); step();
    chk("zero_32",   64'(b0.out_operand), 64'h0);

    drive(1'b1, 32'h800000B7, SEL_U, 64'h0, 1'b1); step();
    chk("u_neg_32",  64'(b0.out_operand), 64'h8000_0000);
    chk("u_neg_z32", 64'(b1.out_operand), 64'h8000_0000);
    chk("u_neg_64",  64'(b2.out_operand), 64'hFFFF_FFFF_8000_0000);

    drive(1'b1, 32'h03F00093, SEL_SHAMT, 64'h0, 1'b1); step();
    chk("shamt63_64", 64'(b2.out_operand), 64'h3F);
    chk("shamt31_32", 64'(b0.out_operand), 64'h1F);

    drive(1'b0, 32'h0, SEL_ZERO, 64'h0, 1'b1); step();
    chk("idle_valid", 64'(b0.out_valid), 64'h0);

    // Backpressure: 4 entries against 3 stalled cycles, then drain in order.
    drive(1'b1, 32'h0, SEL_RS2, 64'd1, 1'b0); step();
    chk("bp1_op",    64'(b0.out_operand), 64'd1);
    chk("bp1_rdy",   64'(b0.in_ready),    64'h1);
    drive(1'b1, 32'h0, SEL_RS2, 64'd2, 1'b0); step();
    chk("bp2_op",    64'(b0.out_operand), 64'd1);
    chk("bp2_rdy",   64'(b0.in_ready),    64'h0);
    drive(1'b1, 32'h0, SEL_RS2, 64'd3, 1'b0); step();
    chk("bp3_valid", 64'(b0.out_valid),   64'h1);
    chk("bp3_op",    64'(b0.out_operand), 64'd1);
    chk("bp3_rdy",   64'(b0.in_ready),    64'h0);
    drive(1'b1, 32'h0, SEL_RS2, 64'd3, 1'b1); step();
    chk("dr2_op",    64'(b0.out_operand), 64'd2);
    chk("dr2_rdy",   64'(b0.in_ready),    64'h1);
    drive(1'b1, 32'h0, SEL_RS2, 64'd3, 1'b1); step();
    chk("dr3_op",    64'(b0.out_operand), 64'd3);
    drive(1'b1, 32'h0, SEL_RS2, 64'd4, 1'b1); step();
    chk("dr4_op",    64'(b0.out_operand), 64'd4);
    chk("dr4_valid", 64'(b0.out_valid),   64'h1);
    drive(1'b0, 32'h0, SEL_ZERO, 64'h0, 1'b1); step();
    chk("dr_empty",  64'(b0.out_valid),   64'h0);

    // Flush with both entries full; the flush-cycle input is discarded.
    drive(1'b1, 32'h0, SEL_RS2, 64'd5, 1'b0); step();
    drive(1'b1, 32'h0, SEL_RS2, 64'd6, 1'b0); step();
    chk("fl_full_rdy", 64'(b0.in_ready), 64'h0);
    flush = 1'b1;
    drive(1'b1, 32'h0, SEL_RS2, 64'd7, 1'b0); step();
    flush = 1'b0;
    chk("fl_valid",  64'(b0.out_valid), 64'h0);
    chk("fl_rdy",    64'(b0.in_ready),  64'h1);
    drive(1'b1, 32'h0, SEL_RS2, 64'd8, 1'b1); step();
    chk("fl_new_op", 64'(b0.out_operand), 64'd8);
    chk("fl_new_vl", 64'(b0.out_valid),   64'h1);
    drive(1'b0, 32'h0, SEL_ZERO, 64'h0, 1'b1); step();
    chk("fl_alone",  64'(b0.out_valid),   64'h0);

    // Reset mid-stream together with flush and a presented entry.
    drive(1'b1, 32'h0, SEL_RS2, 64'd9, 1'b0); step();
    drive(1'b1, 32'h0, SEL_RS2, 64'd10, 1'b0); step();
    rst   = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h0, SEL_RS2, 64'd11, 1'b0); step();
    rst   = 1'b0;
    flush = 1'b0;
    chk("mr_valid",   64'(b0.out_valid),   64'h0);
    chk("mr_op",      64'(b0.out_operand), 64'h0);
    chk("mr_op64",    64'(b2.out_operand), 64'h0);
    chk("mr_illegal", 64'(b0.out_illegal), 64'h0);
    chk("mr_rdy",     64'(b0.in_ready),    64'h1);
    drive(1'b0, 32'h0, SEL_ZERO, 64'h0, 1'b1); step();
    chk("mr_none",    64'(b0.out_valid),   64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
